// File: rtl/pixel_frame_sink.sv
`default_nettype none
// ============================================================================
// Module      : pixel_frame_sink
// Description : Responder for the xAddr/yAddr/pixelData/pixelWrite/pixelReady
//               pixel write handshake. It stores accepted pixels in an on-chip
//               RGB565 frame buffer so that drawing engines can run without a
//               panel attached. A registered read port exposes the frame
//               contents for scan-out and checking.
//
// Ports
//   clock       in   1   single clock, all logic on the rising edge
//   reset_n     in   1   synchronous active-low reset
//   xAddr       in   8   write column
//   yAddr       in   9   write row
//   pixelData   in  16   write colour (RGB565)
//   pixelWrite  in   1   write request, held by the writer until accepted
//   pixelReady  out  1   sink accepts a write on this edge
//   rdXAddr     in   8   read column
//   rdYAddr     in   9   read row
//   rdData      out 16   read colour, one cycle after the address
//   clearBusy   out  1   frame buffer is being filled with CLEAR_COLOUR
//   errorCount  out  8   out-of-range writes since reset, saturates at 255
//
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_sink #(
   parameter int          WIDTH        = 240,
   parameter int          HEIGHT       = 320,
   parameter int          BUSY_CYCLES  = 4,
   parameter logic [15:0] CLEAR_COLOUR = 16'h0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  xAddr,
   input  logic [8:0]  yAddr,
   input  logic [15:0] pixelData,
   input  logic        pixelWrite,
   output logic        pixelReady,
   input  logic [7:0]  rdXAddr,
   input  logic [8:0]  rdYAddr,
   output logic [15:0] rdData,
   output logic        clearBusy,
   output logic [7:0]  errorCount
);

   // -------------------------------------------------------------------------
   // Derived constants
   // -------------------------------------------------------------------------
   localparam int NUM_PIXELS = WIDTH * HEIGHT;
   // Linear addresses are carried in 17 bits so y*WIDTH+x never truncates.
   localparam int ADDR_W     = 17;
   localparam int MEM_AW     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int CNT_W      = $clog2(BUSY_CYCLES + 1);

   localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0] HEIGHT_A  = ADDR_W'(HEIGHT);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [CNT_W-1:0]  BUSY_LOAD = CNT_W'(BUSY_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [7:0]        ERR_MAX   = 8'hFF;

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_BUSY  = 2'd3;

   // A zero busy period would let the counter underflow in BUSY.
   generate
      if (BUSY_CYCLES < 1) begin : g_busy_cycles_invalid
         $error("pixel_frame_sink: BUSY_CYCLES must be >= 1");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Address helpers
   // -------------------------------------------------------------------------
   function automatic logic [ADDR_W-1:0] linear_addr(input logic [7:0] x,
                                                     input logic [8:0] y);
      return ({8'd0, y} * WIDTH_A) + {9'd0, x};
   endfunction

   function automatic logic in_frame(input logic [7:0] x,
                                     input logic [8:0] y);
      return ({9'd0, x} < WIDTH_A) && ({8'd0, y} < HEIGHT_A);
   endfunction

   // -------------------------------------------------------------------------
   // Declarations
   // -------------------------------------------------------------------------
   logic [1:0]        state;
   logic [1:0]        next_state;

   logic [ADDR_W-1:0] clr_addr;
   logic [CNT_W-1:0]  busy_cnt;

   // Write captured at the accept edge; later input changes are ignored.
   logic [7:0]        cap_x;
   logic [8:0]        cap_y;
   logic [15:0]       cap_data;

   logic              accept;
   logic              cap_in_frame;
   logic              mem_we;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              err_inc;

   logic              rd_in_frame;
   logic [ADDR_W-1:0] rd_addr;

   logic [15:0]       mem [0:NUM_PIXELS-1];

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_CLEAR;
      end else begin
         state <= next_state;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         ST_CLEAR: begin
            if (clr_addr == LAST_ADDR) begin
               next_state = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (pixelWrite && pixelReady) begin
               next_state = ST_WRITE;
            end
         end
         ST_WRITE: begin
            next_state = ST_BUSY;
         end
         ST_BUSY: begin
            if (busy_cnt == CNT_ONE) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_CLEAR;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: output decode (strobes for the registered datapath)
   // -------------------------------------------------------------------------
   always_comb begin
      accept       = 1'b0;
      mem_we       = 1'b0;
      wr_addr      = clr_addr;
      wr_data      = CLEAR_COLOUR;
      err_inc      = 1'b0;
      cap_in_frame = in_frame(cap_x, cap_y);
      case (state)
         ST_CLEAR: begin
            // Gated by reset_n so a reset edge never writes memory.
            mem_we = reset_n;
         end
         ST_IDLE: begin
            accept = pixelWrite && pixelReady;
         end
         ST_WRITE: begin
            wr_addr = linear_addr(cap_x, cap_y);
            wr_data = cap_data;
            mem_we  = reset_n && cap_in_frame;
            err_inc = !cap_in_frame && (errorCount != ERR_MAX);
         end
         default: begin
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registered control outputs, clear sweep, busy counter, error counter
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pixelReady <= 1'b0;
         clearBusy  <= 1'b1;
         errorCount <= 8'd0;
         clr_addr   <= '0;
         busy_cnt   <= '0;
      end else begin
         // Ready/busy follow the state being entered so they line up with it.
         pixelReady <= (next_state == ST_IDLE);
         clearBusy  <= (next_state == ST_CLEAR);

         if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + ADDR_W'(1);
         end

         if (state == ST_WRITE) begin
            busy_cnt <= BUSY_LOAD;
         end else if (state == ST_BUSY) begin
            busy_cnt <= busy_cnt - CNT_ONE;
         end

         if (err_inc) begin
            errorCount <= errorCount + 8'd1;
         end
      end
   end

   // Capture registers need no reset: a pending write is abandoned simply
   // because reset forces the FSM back to CLEAR.
   always_ff @(posedge clock) begin
      if (accept) begin
         cap_x    <= xAddr;
         cap_y    <= yAddr;
         cap_data <= pixelData;
      end
   end

   // -------------------------------------------------------------------------
   // Frame buffer: one write port, one registered read port
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[wr_addr[MEM_AW-1:0]] <= wr_data;
      end
   end

   assign rd_in_frame = in_frame(rdXAddr, rdYAddr);
   assign rd_addr     = linear_addr(rdXAddr, rdYAddr);

   // Read-before-write: a same-edge read of the written word returns old data.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rdData <= 16'h0000;
      end else if (rd_in_frame) begin
         rdData <= mem[rd_addr[MEM_AW-1:0]];
      end else begin
         rdData <= 16'h0000;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_frame_sink
// Description : Directed self-checking bench for pixel_frame_sink using a
//               4x3 frame, CLEAR_COLOUR 16'hABCD and a 4-cycle busy period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_sink;

   localparam int          WIDTH  = 4;
   localparam int          HEIGHT = 3;
   localparam int          BUSY   = 4;
   localparam logic [15:0] CLR    = 16'hABCD;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  xAddr = '0;
   logic [8:0]  yAddr = '0;
   logic [15:0] pixelData = '0;
   logic        pixelWrite = 1'b0;
   logic        pixelReady;
   logic [7:0]  rdXAddr = '0;
   logic [8:0]  rdYAddr = '0;
   logic [15:0] rdData;
   logic        clearBusy;
   logic [7:0]  errorCount;

   int pass_cnt  = 0;
   int total_cnt = 0;

   pixel_frame_sink #(
      .WIDTH        (WIDTH),
      .HEIGHT       (HEIGHT),
      .BUSY_CYCLES  (BUSY),
      .CLEAR_COLOUR (CLR)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .xAddr      (xAddr),
      .yAddr      (yAddr),
      .pixelData  (pixelData),
      .pixelWrite (pixelWrite),
      .pixelReady (pixelReady),
      .rdXAddr    (rdXAddr),
      .rdYAddr    (rdYAddr),
      .rdData     (rdData),
      .clearBusy  (clearBusy),
      .errorCount (errorCount)
   );

   always #5 clock = ~clock;

   // Advance one rising edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Registered read: present address, one edge, return data.
   task automatic read_px(input int x, input int y, output logic [15:0] d);
      rdXAddr = 8'(x);
      rdYAddr = 9'(y);
      tick();
      d = rdData;
   endtask

   // Bounded wait for pixelReady; a timeout counts as a failed comparison.
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!pixelReady && n < 200) begin
         tick();
         n++;
      end
      if (!pixelReady) begin
         total_cnt++;
         $display("FAIL %s: pixelReady timeout, got %0b want 1", tag, pixelReady);
      end
   endtask

   // One write with pixelWrite dropped after acceptance; returns how many
   // sampled cycles pixelReady stayed low after the accept edge.
   task automatic do_write(input int x, input int y, input logic [15:0] d,
                           output int low);
      wait_ready("do_write");
      xAddr      = 8'(x);
      yAddr      = 9'(y);
      pixelData  = d;
      pixelWrite = 1'b1;
      tick();
      pixelWrite = 1'b0;
      low = 0;
      while (!pixelReady && low < 30) begin
         low++;
         tick();
      end
   endtask

   task automatic test_reset();
      int n;
      logic [15:0] d;
      logic bad_busy;
      reset_n = 1'b0;
      rdXAddr = 8'd1;
      rdYAddr = 9'd1;
      tick();
      tick();
      total_cnt++;
      if (pixelReady !== 1'b0) $display("FAIL reset_ready: got %0b want 0", pixelReady);
      else pass_cnt++;
      total_cnt++;
      if (clearBusy !== 1'b1) $display("FAIL reset_clearbusy: got %0b want 1", clearBusy);
      else pass_cnt++;
      total_cnt++;
      if (errorCount !== 8'd0) $display("FAIL reset_errcount: got %0d want 0", errorCount);
      else pass_cnt++;
      total_cnt++;
      if (rdData !== 16'h0000) $display("FAIL reset_rddata: got %h want 0000", rdData);
      else pass_cnt++;

      reset_n  = 1'b1;
      n        = 0;
      bad_busy = 1'b0;
      while (!pixelReady && n < 100) begin
         tick();
         n++;
         if (!pixelReady && clearBusy !== 1'b1) bad_busy = 1'b1;
      end
      total_cnt++;
      if (n !== 12) $display("FAIL clear_duration: got %0d edges want 12", n);
      else pass_cnt++;
      total_cnt++;
      if (bad_busy || clearBusy !== 1'b0)
         $display("FAIL clear_busy_flag: dropped_early=%0b final=%0b want 0/0", bad_busy, clearBusy);
      else pass_cnt++;

      for (int y = 0; y < HEIGHT; y++) begin
         for (int x = 0; x < WIDTH; x++) begin
            read_px(x, y, d);
            total_cnt++;
            if (d !== CLR) $display("FAIL clear_read(%0d,%0d): got %h want %h", x, y, d, CLR);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_single_write();
      int low;
      logic [15:0] d;
      wait_ready("single");
      rdXAddr    = 8'd3;
      rdYAddr    = 9'd2;
      xAddr      = 8'd3;
      yAddr      = 9'd2;
      pixelData  = 16'hF800;
      pixelWrite = 1'b1;
      tick();                       // accept edge A
      pixelWrite = 1'b0;
      low = 0;
      if (!pixelReady) low++;
      tick();                       // write edge A+1: read sees old data
      if (!pixelReady) low++;
      total_cnt++;
      if (rdData !== CLR) $display("FAIL same_edge_read: got %h want %h", rdData, CLR);
      else pass_cnt++;
      tick();                       // A+2: new data visible
      if (!pixelReady) low++;
      total_cnt++;
      if (rdData !== 16'hF800) $display("FAIL next_edge_read: got %h want F800", rdData);
      else pass_cnt++;
      while (!pixelReady && low < 30) begin
         tick();
         if (!pixelReady) low++;
      end
      total_cnt++;
      if (low !== 5) $display("FAIL single_ready_low: got %0d cycles want 5", low);
      else pass_cnt++;
      read_px(2, 2, d);
      total_cnt++;
      if (d !== CLR) $display("FAIL neighbour_untouched: got %h want %h", d, CLR);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int k;
      logic prev;
      logic [15:0] first_val;
      logic [15:0] d;
      wait_ready("b2b");
      rdXAddr    = 8'd0;
      rdYAddr    = 9'd0;
      xAddr      = 8'd0;
      yAddr      = 9'd0;
      pixelData  = 16'h1111;
      pixelWrite = 1'b1;
      tick();                       // first accept
      pixelData  = 16'h07E0;        // changes before the write edge
      first_val  = 16'hxxxx;
      prev       = pixelReady;
      k          = 0;
      do begin
         tick();
         k++;
         if (k == 2) first_val = rdData;
         if (prev && !pixelReady) break;
         prev = pixelReady;
      end while (k < 40);
      pixelWrite = 1'b0;
      total_cnt++;
      if (first_val !== 16'h1111) $display("FAIL input_latched: got %h want 1111", first_val);
      else pass_cnt++;
      total_cnt++;
      if (k !== 6) $display("FAIL second_accept: got %0d edges want 6", k);
      else pass_cnt++;
      wait_ready("b2b_done");
      read_px(0, 0, d);
      total_cnt++;
      if (d !== 16'h07E0) $display("FAIL held_write_data: got %h want 07E0", d);
      else pass_cnt++;
   endtask

   task automatic test_out_of_range();
      int low;
      int bad_low;
      logic [15:0] d;
      do_write(4, 0, 16'h5555, low);
      total_cnt++;
      if (errorCount !== 8'd1 || low !== 5)
         $display("FAIL oor_x: errorCount=%0d low=%0d want 1/5", errorCount, low);
      else pass_cnt++;
      do_write(0, 3, 16'h6666, low);
      total_cnt++;
      if (errorCount !== 8'd2 || low !== 5)
         $display("FAIL oor_y: errorCount=%0d low=%0d want 2/5", errorCount, low);
      else pass_cnt++;
      bad_low = 0;
      for (int i = 0; i < 300; i++) begin
         do_write(7 + (i % 5), i % 3, 16'(i), low);
         if (low !== 5) bad_low++;
      end
      total_cnt++;
      if (errorCount !== 8'd255) $display("FAIL oor_saturate: got %0d want 255", errorCount);
      else pass_cnt++;
      total_cnt++;
      if (bad_low !== 0) $display("FAIL oor_handshake: got %0d bad handshakes want 0", bad_low);
      else pass_cnt++;
      read_px(0, 1, d);             // linear alias of (4,0)
      total_cnt++;
      if (d !== CLR) $display("FAIL oor_alias_untouched: got %h want %h", d, CLR);
      else pass_cnt++;
      read_px(3, 2, d);
      total_cnt++;
      if (d !== 16'hF800) $display("FAIL oor_mem_kept: got %h want F800", d);
      else pass_cnt++;
   endtask

   task automatic test_read_out_of_range();
      logic [15:0] d;
      read_px(200, 0, d);
      total_cnt++;
      if (d !== 16'h0000) $display("FAIL rd_oor_x: got %h want 0000", d);
      else pass_cnt++;
      read_px(1, 1, d);
      total_cnt++;
      if (d !== CLR) $display("FAIL rd_inrange: got %h want %h", d, CLR);
      else pass_cnt++;
      read_px(0, 3, d);
      total_cnt++;
      if (d !== 16'h0000) $display("FAIL rd_oor_y: got %h want 0000", d);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_write();
      int n;
      logic early_ready;
      logic [15:0] d;
      wait_ready("mid_reset");
      xAddr      = 8'd2;
      yAddr      = 9'd1;
      pixelData  = 16'hBEEF;
      pixelWrite = 1'b1;
      tick();                       // accept edge A
      pixelWrite = 1'b0;
      reset_n    = 1'b0;
      tick();                       // reset on what would be the write edge
      reset_n    = 1'b1;
      total_cnt++;
      if (errorCount !== 8'd0 || clearBusy !== 1'b1 || pixelReady !== 1'b0)
         $display("FAIL mid_reset_state: err=%0d busy=%0b ready=%0b want 0/1/0",
                  errorCount, clearBusy, pixelReady);
      else pass_cnt++;
      n = 0;
      early_ready = 1'b0;
      while (!pixelReady && n < 100) begin
         tick();
         n++;
         if (pixelReady && n < 12) early_ready = 1'b1;
      end
      total_cnt++;
      if (n !== 12 || early_ready)
         $display("FAIL mid_reset_clear: got %0d edges early=%0b want 12/0", n, early_ready);
      else pass_cnt++;
      read_px(2, 1, d);
      total_cnt++;
      if (d !== CLR) $display("FAIL dropped_write: got %h want %h", d, CLR);
      else pass_cnt++;
      read_px(3, 2, d);
      total_cnt++;
      if (d !== CLR) $display("FAIL reclear: got %h want %h", d, CLR);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_out_of_range();
      test_read_out_of_range();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pixel_frame_sink.md
# pixel_frame_sink

Pixel-interface responder: accepts the pixel write handshake (xAddr/yAddr/pixelData/pixelWrite/pixelReady) that drawing blocks already use toward the LT24 display. It stores each accepted pixel in an on-chip 16-bit RGB565 frame buffer. It is a drop-in stand-in for the display when drawing engines are simulated or run without a panel. A registered read port exposes frame contents for scan-out and checking.

## Interface
- WIDTH, 240, frame columns (x range 0..WIDTH-1)
- HEIGHT, 320, frame rows (y range 0..HEIGHT-1)
- BUSY_CYCLES, 4, post-accept busy period in cycles; must be >= 1
- CLEAR_COLOUR, 16'h0000, value written to every location after reset
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- xAddr  in  8  write column
- yAddr  in  9  write row
- pixelData  in  16  write colour
- pixelWrite  in  1  write request; writer holds high until it sees pixelReady
- pixelReady  out  1  sink can accept a write this cycle
- rdXAddr  in  8  read column
- rdYAddr  in  9  read row
- rdData  out  16  read colour, 1-cycle latency
- clearBusy  out  1  high while the frame buffer is being cleared
- errorCount  out  8  out-of-range writes since reset, saturating at 255

## Operation
- Memory: WIDTH*HEIGHT words x 16 bits, single write port, single read port.
- Linear address = y*WIDTH + x, computed in 17 bits with no truncation.
- States:
  - CLEAR: writes CLEAR_COLOUR to address clrAddr each cycle, clrAddr 0..WIDTH*HEIGHT-1. After the last address, goes to IDLE.
  - IDLE: pixelReady=1. On pixelWrite=1, captures xAddr/yAddr/pixelData, drops pixelReady, goes to WRITE.
  - WRITE: if the captured x<WIDTH and y<HEIGHT, writes memory. Otherwise discards the data and increments errorCount, saturating at 255. Loads busy counter with BUSY_CYCLES and goes to BUSY.
  - BUSY: decrements the counter. On the edge where the counter is 1, goes to IDLE and sets pixelReady<=1.
- Handshake:
  - A write is accepted only on an edge where state=IDLE, pixelReady=1 and pixelWrite=1. Inputs are sampled on that edge only; later input changes are ignored.
  - If pixelWrite stays high through the busy period, a further write is accepted on the next IDLE edge, using the inputs then present. Writers must drop pixelWrite after observing acceptance to avoid a duplicate write.
- Read port:
  - rdData <= mem[rdY*WIDTH+rdX] every cycle in every state.
  - An out-of-range read address gives rdData <= 0.
  - Reading the address being written on the same edge returns the old data.
- Reset (reset_n low on an edge), in any state including mid-write or mid-clear:
  - pixelReady=0, clearBusy=1, errorCount=0, rdData=0, clrAddr=0, state=CLEAR.
  - Any captured pending write is dropped.
  - Memory contents are not reset directly; they are overwritten by the CLEAR pass.

## Timing
- Reset values: pixelReady 0, clearBusy 1, errorCount 0, rdData 0. All outputs are registered.
- Clear duration: the first edge with reset_n high writes address 0. Address N-1 (N=WIDTH*HEIGHT) is written N-1 edges later. On that same edge clearBusy<=0 and pixelReady<=1. Default clear is 76800 cycles.
- Write handshake:
  - Accept at edge A. pixelReady is low from A+1.
  - Memory is updated at edge A+1.
  - pixelReady returns high after edge A+1+BUSY_CYCLES. It is therefore low for BUSY_CYCLES+1 cycles (5 by default).
  - The earliest next acceptance is edge A+2+BUSY_CYCLES.
- Read latency: address presented before edge R gives data valid after edge R. A write at edge A+1 is visible to a read issued at edge A+2 or later.
- errorCount updates at the WRITE edge, i.e. A+1.
- pixelReady never rises during CLEAR, even if pixelWrite is high.

## Test plan
- Reset and clear with WIDTH=4, HEIGHT=3, CLEAR_COLOUR=16'hABCD: release reset_n -> clearBusy high for 12 cycles, pixelReady rises exactly 12 edges after release, and all 12 reads return 16'hABCD.
- Single write (x=3, y=2, data=16'hF800), pixelWrite dropped after acceptance -> pixelReady low for 5 cycles, and a read of (3,2) one cycle after the write edge returns 16'hF800; (2,2) still returns CLEAR_COLOUR.
- Writer holding pixelWrite high with data changing to 16'h07E0 during busy -> the second acceptance occurs exactly 6 edges after the first, and the stored value is 16'h07E0.
- Out-of-range writes (x=4,y=0), then (x=0,y=3), then 300 further out-of-range writes -> memory unchanged, errorCount goes 1, 2, then saturates at 255, and the handshake completes normally every time.
- reset_n asserted one cycle after an acceptance (before the WRITE edge) -> the target location stays CLEAR_COLOUR after the re-clear, errorCount=0, and pixelReady stays low until the clear completes.
- Read of an out-of-range address (rdX=200, WIDTH=4) -> rdData=0; read of the write address on the write edge -> old value, new value one cycle later.
